// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU-control opcodes, controller state encoding and mux selects
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [5:0] {
        ALU_RTYPE  = 6'h00,
        ALU_REGIMM = 6'h01,
        ALU_BEQ    = 6'h04,
        ALU_BNE    = 6'h05,
        ALU_BLEZ   = 6'h06,
        ALU_BGTZ   = 6'h07,
        ALU_ADDIU  = 6'h09,
        ALU_SLTI   = 6'h0A,
        ALU_SLTIU  = 6'h0B,
        ALU_ANDI   = 6'h0C,
        ALU_ORI    = 6'h0D,
        ALU_XORI   = 6'h0E,
        ALU_SUBIU  = 6'h10
    } alu_op_sel_t;

    typedef enum logic [4:0] {
        S_INIT       = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC_R     = 5'd4,
        S_R_WB       = 5'd5,
        S_EXEC_I     = 5'd6,
        S_I_WB       = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_LW_READ    = 5'd9,
        S_LW_WAIT    = 5'd10,
        S_LW_WB      = 5'd11,
        S_SW_WRITE   = 5'd12,
        S_BRANCH     = 5'd13,
        S_JUMP       = 5'd14,
        S_JAL        = 5'd15,
        S_JR         = 5'd16,
        S_HALT       = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_SUBIU  = 6'h10;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;

    localparam logic [1:0] SRCB_REGB   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mips_controller.sv
// ============================================================================
// Module : mips_controller
// Brief  : Multi-cycle MIPS Moore control FSM with stall enable
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_controller
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] ir_31_to_26,
    input  logic [5:0] ir_5_to_0,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       jump_and_link,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       is_signed,
    output logic [1:0] pc_source,
    output logic [5:0] alu_op,
    output logic       alu_en
);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_reg;
    logic [5:0] fn_reg;

    // IR fields are latched as the fetch completes so later IR changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_INIT;
            op_reg <= 6'd0;
            fn_reg <= 6'd0;
        end else if (en) begin
            state <= next_state;
            if (state == S_FETCH_WAIT) begin
                op_reg <= ir_31_to_26;
                fn_reg <= ir_5_to_0;
            end
        end
    end

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        jump_and_link = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        is_signed     = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_RTYPE;
        alu_en        = 1'b0;

        case (state)
            S_INIT: next_state = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALU_ADDIU;
                pc_write   = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                mem_read   = 1'b1;
                ir_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADDIU;
                case (op_reg)
                    OP_RTYPE:                 next_state = S_EXEC_R;
                    OP_LW, OP_SW:             next_state = S_MEM_ADDR;
                    OP_J:                     next_state = S_JUMP;
                    OP_JAL:                   next_state = S_JAL;
                    OP_REGIMM, OP_BEQ, OP_BNE,
                    OP_BLEZ, OP_BGTZ:         next_state = S_BRANCH;
                    OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_SUBIU: next_state = S_EXEC_I;
                    OP_HALT:                  next_state = S_HALT;
                    default:                  next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
                alu_en    = 1'b1;
                if (fn_reg == FN_JR)
                    next_state = S_JR;
                else if (fn_reg == FN_MULT || fn_reg == FN_MULTU)
                    next_state = S_FETCH;
                else
                    next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = op_reg;
                // logical immediates zero-extend
                is_signed  = !(op_reg inside {OP_ANDI, OP_ORI, OP_XORI});
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                is_signed  = 1'b1;
                alu_op     = ALU_ADDIU;
                next_state = (op_reg == OP_SW) ? S_SW_WRITE : S_LW_READ;
            end
            S_LW_READ: begin
                i_or_d     = 1'b1;
                mem_read   = 1'b1;
                next_state = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                i_or_d     = 1'b1;
                mem_read   = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_SW_WRITE: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = op_reg;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                pc_source     = PCSRC_JUMP;
                pc_write      = 1'b1;
                jump_and_link = 1'b1;
                reg_write     = 1'b1;
                next_state    = S_FETCH;
            end
            S_JR: begin
                pc_source  = PCSRC_ALU;
                alu_op     = ALU_RTYPE;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_INIT;
        endcase

        // a stall must never commit architectural state
        if (!en) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            alu_en        = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_controller.sv
// ============================================================================
// Module : tb_mips_controller
// Brief  : Scoreboard bench: per-cycle expected control words vs. DUT outputs
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] ir_31_to_26;
    logic [5:0] ir_5_to_0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, jump_and_link, alu_src_a;
    logic [1:0] alu_src_b;
    logic       is_signed;
    logic [1:0] pc_source;
    logic [5:0] alu_op;
    logic       alu_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [22:0] v;
    } exp_t;
    exp_t sb[$];

    mips_controller dut (
        .clk(clk), .rst(rst), .en(en),
        .ir_31_to_26(ir_31_to_26), .ir_5_to_0(ir_5_to_0),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .jump_and_link(jump_and_link), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .is_signed(is_signed), .pc_source(pc_source), .alu_op(alu_op), .alu_en(alu_en)
    );

    always #5 clk = ~clk;

    logic [22:0] act;
    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, jump_and_link, alu_src_a,
                  alu_src_b, is_signed, pc_source, alu_op, alu_en};

    function automatic logic [22:0] ov(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, jal, asa,
        input logic [1:0] asb, input logic sgn, input logic [1:0] pcs,
        input logic [5:0] aop, input logic aen);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, jal, asa, asb, sgn, pcs, aop, aen};
    endfunction

    localparam logic [22:0] V_ZERO   = 23'd0;
    localparam logic [22:0] V_FETCH  = ov(1,0,0,1,0,0,0,0,0,0,0,2'd1,0,2'd0,6'h09,0);
    localparam logic [22:0] V_FSTALL = ov(0,0,0,1,0,0,0,0,0,0,0,2'd1,0,2'd0,6'h09,0);
    localparam logic [22:0] V_FWAIT  = ov(0,0,0,1,0,1,0,0,0,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_DECODE = ov(0,0,0,0,0,0,0,0,0,0,0,2'd3,0,2'd0,6'h09,0);
    localparam logic [22:0] V_EXECR  = ov(0,0,0,0,0,0,0,0,0,0,1,2'd0,0,2'd0,6'h00,1);
    localparam logic [22:0] V_RWB    = ov(0,0,0,0,0,0,0,1,1,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_IWB    = ov(0,0,0,0,0,0,0,0,1,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_MADDR  = ov(0,0,0,0,0,0,0,0,0,0,1,2'd2,1,2'd0,6'h09,0);
    localparam logic [22:0] V_LWRD   = ov(0,0,1,1,0,0,0,0,0,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_LWWB   = ov(0,0,0,0,0,0,1,0,1,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_SWWR   = ov(0,0,1,0,1,0,0,0,0,0,0,2'd0,0,2'd0,6'h00,0);
    localparam logic [22:0] V_JUMP   = ov(1,0,0,0,0,0,0,0,0,0,0,2'd0,0,2'd2,6'h00,0);
    localparam logic [22:0] V_JAL    = ov(1,0,0,0,0,0,0,0,1,1,0,2'd0,0,2'd2,6'h00,0);
    localparam logic [22:0] V_JR     = ov(1,0,0,0,0,0,0,0,0,0,0,2'd0,0,2'd0,6'h00,0);

    // monitor: one scoreboard entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.v, $time);
            end
        end
    end

    task automatic cyc(input string name, input logic [22:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic set_en_mid(input logic val);
        @(negedge clk);
        #1 en = val;
    endtask

    // FETCH, FETCH_WAIT, DECODE; IR is scrambled after capture to prove it is ignored
    task automatic front(input logic [5:0] op, input logic [5:0] fn);
        ir_31_to_26 = op;
        ir_5_to_0   = fn;
        cyc("FETCH", V_FETCH);
        cyc("FETCH_WAIT", V_FWAIT);
        cyc("DECODE", V_DECODE);
        ir_31_to_26 = 6'h3F;
        ir_5_to_0   = 6'h08;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        ir_31_to_26 = 6'h00;
        ir_5_to_0   = 6'h00;
        cyc("RESET", V_ZERO);
        cyc("RESET", V_ZERO);
        rst = 1'b0;                       // this cycle is INIT

        // ADDU
        front(6'h00, 6'h21);
        cyc("EXEC_R", V_EXECR);
        cyc("R_WB", V_RWB);

        // LW with a 3-cycle stall in LW_WAIT
        front(6'h23, 6'h00);
        cyc("MEM_ADDR", V_MADDR);
        cyc("LW_READ", V_LWRD);
        cyc("LW_WAIT", V_LWRD);
        set_en_mid(1'b0);
        cyc("LW_WAIT_STALL", V_LWRD);
        cyc("LW_WAIT_STALL", V_LWRD);
        cyc("LW_WAIT_STALL", V_LWRD);
        set_en_mid(1'b1);
        cyc("LW_WB", V_LWWB);

        // SW
        front(6'h2B, 6'h00);
        cyc("MEM_ADDR", V_MADDR);
        cyc("SW_WRITE", V_SWWR);

        // ORI (zero-extend) and SLTI (sign-extend)
        front(6'h0D, 6'h00);
        cyc("EXEC_I_ORI", ov(0,0,0,0,0,0,0,0,0,0,1,2'd2,0,2'd0,6'h0D,0));
        cyc("I_WB", V_IWB);
        front(6'h0A, 6'h00);
        cyc("EXEC_I_SLTI", ov(0,0,0,0,0,0,0,0,0,0,1,2'd2,1,2'd0,6'h0A,0));
        cyc("I_WB", V_IWB);

        // BEQ, BGTZ
        front(6'h04, 6'h00);
        cyc("BRANCH_BEQ", ov(0,1,0,0,0,0,0,0,0,0,1,2'd0,0,2'd1,6'h04,0));
        front(6'h07, 6'h00);
        cyc("BRANCH_BGTZ", ov(0,1,0,0,0,0,0,0,0,0,1,2'd0,0,2'd1,6'h07,0));

        // J, JAL, JR, MULT, undefined opcode
        front(6'h02, 6'h00);
        cyc("JUMP", V_JUMP);
        front(6'h03, 6'h00);
        cyc("JAL", V_JAL);
        front(6'h00, 6'h08);
        cyc("EXEC_R_JR", V_EXECR);
        cyc("JR", V_JR);
        front(6'h00, 6'h18);
        cyc("EXEC_R_MULT", V_EXECR);
        front(6'h3E, 6'h00);              // ignored opcode: straight back to FETCH

        // stall in FETCH masks pc_write but keeps the read
        ir_31_to_26 = 6'h00;
        ir_5_to_0   = 6'h21;
        cyc("FETCH", V_FETCH);
        set_en_mid(1'b0);
        cyc("FETCH_STALL", V_FSTALL);
        set_en_mid(1'b1);
        cyc("FETCH_WAIT", V_FWAIT);
        cyc("DECODE", V_DECODE);
        cyc("EXEC_R", V_EXECR);
        cyc("R_WB", V_RWB);

        // HALT is absorbing
        front(6'h3F, 6'h00);
        for (int i = 0; i < 4; i++) cyc("HALT", V_ZERO);

        // reset out of HALT, then abort a store mid-write
        @(negedge clk);
        #1 rst = 1'b1;
        cyc("RESET", V_ZERO);
        rst = 1'b0;
        front(6'h2B, 6'h00);
        cyc("MEM_ADDR", V_MADDR);
        cyc("SW_WRITE", V_SWWR);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || act !== V_ZERO) begin
            errors++;
            $display("FAIL async_reset_sw: got %h expected %h", act, V_ZERO);
        end
        cyc("RESET", V_ZERO);
        rst = 1'b0;
        front(6'h00, 6'h23);
        cyc("EXEC_R", V_EXECR);
        cyc("R_WB", V_RWB);
        cyc("FETCH", V_FETCH);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
